// File: rtl/match_pkg.sv
// Shared types and constants for the match controller: FSM states,
// winner encodings and default timing/score parameters.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    PLAY,
    ROUND_END,
    MATCH_END
  } state_t;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] P1   = 2'b01;
  localparam logic [1:0] P2   = 2'b10;

  localparam int unsigned DEF_WINS_TO_MATCH = 4;
  localparam int unsigned DEF_COUNT_TICKS   = 3;
  localparam int unsigned DEF_HOLD_TICKS    = 2;

  localparam int unsigned TIMER_W = 3;

endpackage

// File: rtl/match_ctrl_tick_timer.sv
// Loadable down-counter stepped by the timebase strobe; done fires on the
// strobe that consumes the last remaining tick.
module tick_timer
  import match_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         done
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  always_comb begin
    done = run && tick && (count == W'(1));
  end

endmodule

// File: rtl/match_ctrl.sv
// Round/match sequencing for a two-player game: countdown, play, round
// hold-off and match end, with score keeping and winner reporting.
module match_ctrl
  import match_pkg::*;
#(
  parameter int unsigned WINS_TO_MATCH = DEF_WINS_TO_MATCH,
  parameter int unsigned COUNT_TICKS   = DEF_COUNT_TICKS,
  parameter int unsigned HOLD_TICKS    = DEF_HOLD_TICKS
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       TickEn,
  input  logic       P1RoundWin,
  input  logic       P2RoundWin,
  output logic       playEn,
  output logic       roundReset,
  output logic [2:0] p1Score,
  output logic [2:0] p2Score,
  output logic [1:0] countdown,
  output logic       matchOver,
  output logic [1:0] winner
);

  state_t ps, ns;

  logic [2:0]         p1_score, p2_score;
  logic [2:0]         p1_next, p2_next;
  logic [1:0]         win_q;
  logic               play_en_q, round_reset_q;
  logic               p1_win, p2_win, p1_takes, p2_takes;
  logic               t_load, t_run, t_done;
  logic [TIMER_W-1:0] t_val, t_count;

  always_comb begin
    p1_win   = P1RoundWin & ~P2RoundWin;
    p2_win   = P2RoundWin & ~P1RoundWin;
    p1_next  = p1_score + 3'd1;
    p2_next  = p2_score + 3'd1;
    p1_takes = p1_win && (p1_next == 3'(WINS_TO_MATCH));
    p2_takes = p2_win && (p2_next == 3'(WINS_TO_MATCH));
  end

  tick_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk      (Clock),
    .reset    (Reset),
    .load     (t_load),
    .load_val (t_val),
    .run      (t_run),
    .tick     (TickEn),
    .count    (t_count),
    .done     (t_done)
  );

  // playEn and roundReset are registered from the next state so they line up
  // exactly with the cycles spent in (or first entering) their states.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ps            <= IDLE;
      play_en_q     <= 1'b0;
      round_reset_q <= 1'b0;
    end else begin
      ps            <= ns;
      play_en_q     <= (ns == PLAY);
      round_reset_q <= (ns == COUNTDOWN) && (ps != COUNTDOWN);
    end
  end

  always_comb begin
    ns = ps;
    unique case (ps)
      IDLE:      if (Start) ns = COUNTDOWN;
      COUNTDOWN: if (t_done) ns = PLAY;
      PLAY: begin
        if (p1_takes || p2_takes)        ns = MATCH_END;
        else if (P1RoundWin || P2RoundWin) ns = ROUND_END;
      end
      ROUND_END: if (t_done) ns = COUNTDOWN;
      MATCH_END: if (Start) ns = IDLE;
      default:   ns = IDLE;
    endcase

    t_run  = (ps == COUNTDOWN) || (ps == ROUND_END);
    t_load = ((ns == COUNTDOWN) && (ps != COUNTDOWN)) ||
             ((ns == ROUND_END) && (ps != ROUND_END));
    t_val  = (ns == COUNTDOWN) ? TIMER_W'(COUNT_TICKS) : TIMER_W'(HOLD_TICKS);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      p1_score <= '0;
      p2_score <= '0;
      win_q    <= NONE;
    end else begin
      case (ps)
        PLAY: begin
          if (p1_win)   p1_score <= p1_next;
          if (p2_win)   p2_score <= p2_next;
          if (p1_takes) win_q    <= P1;
          if (p2_takes) win_q    <= P2;
        end
        MATCH_END: begin
          if (Start) begin
            p1_score <= '0;
            p2_score <= '0;
            win_q    <= NONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    playEn     = play_en_q;
    roundReset = round_reset_q;
    p1Score    = p1_score;
    p2Score    = p2_score;
    winner     = win_q;
    matchOver  = (ps == MATCH_END);
    // countdown loads never exceed 3, so the timer's top bit is clear here
    countdown  = ((ps == COUNTDOWN) && !t_count[2]) ? t_count[1:0] : '0;
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl: directed game scenarios followed by
// random stimulus, checked cycle by cycle against a game-level model.
module tb_match_ctrl;

  localparam int WINS = 4;
  localparam int CT   = 3;
  localparam int HT   = 2;

  logic       Clock = 1'b0;
  logic       Reset, Start, TickEn, P1RoundWin, P2RoundWin;
  logic       playEn, roundReset, matchOver;
  logic [2:0] p1Score, p2Score;
  logic [1:0] countdown, winner;

  always #5 Clock = ~Clock;

  match_ctrl #(
    .WINS_TO_MATCH(WINS),
    .COUNT_TICKS  (CT),
    .HOLD_TICKS   (HT)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .TickEn     (TickEn),
    .P1RoundWin (P1RoundWin),
    .P2RoundWin (P2RoundWin),
    .playEn     (playEn),
    .roundReset (roundReset),
    .p1Score    (p1Score),
    .p2Score    (p2Score),
    .countdown  (countdown),
    .matchOver  (matchOver),
    .winner     (winner)
  );

  // Game-level reference model
  string m_phase = "idle";
  int    m_ticks = 0;
  int    m_s1 = 0, m_s2 = 0, m_win = 0;
  bit    m_fresh = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int mon_cycle = 0;
  logic [12:0] exp_q[$];

  function automatic void model_step(input bit r, s, t, a, b);
    m_fresh = 1'b0;
    if (r) begin
      m_phase = "idle"; m_s1 = 0; m_s2 = 0; m_win = 0; m_ticks = 0;
    end else if (m_phase == "idle") begin
      if (s) begin m_phase = "count"; m_ticks = CT; m_fresh = 1'b1; end
    end else if (m_phase == "count") begin
      if (t) begin
        m_ticks = m_ticks - 1;
        if (m_ticks == 0) m_phase = "play";
      end
    end else if (m_phase == "play") begin
      if (a && b) begin
        m_phase = "hold"; m_ticks = HT;
      end else if (a || b) begin
        if (a) m_s1 = m_s1 + 1;
        else   m_s2 = m_s2 + 1;
        if (m_s1 == WINS)      begin m_phase = "over"; m_win = 1; end
        else if (m_s2 == WINS) begin m_phase = "over"; m_win = 2; end
        else                   begin m_phase = "hold"; m_ticks = HT; end
      end
    end else if (m_phase == "hold") begin
      if (t) begin
        m_ticks = m_ticks - 1;
        if (m_ticks == 0) begin m_phase = "count"; m_ticks = CT; m_fresh = 1'b1; end
      end
    end else if (m_phase == "over") begin
      if (s) begin m_phase = "idle"; m_s1 = 0; m_s2 = 0; m_win = 0; end
    end
  endfunction

  function automatic logic [12:0] model_out();
    logic [1:0] cd;
    cd = (m_phase == "count") ? 2'(m_ticks) : 2'b00;
    return {m_phase == "play", m_fresh, 3'(m_s1), 3'(m_s2), cd,
            m_phase == "over", 2'(m_win)};
  endfunction

  task automatic cyc(input bit r, s, t, a, b);
    Reset = r; Start = s; TickEn = t; P1RoundWin = a; P2RoundWin = b;
    model_step(r, s, t, a, b);
    @(posedge Clock);
    #1;
    exp_q.push_back(model_out());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  always @(negedge Clock) begin
    logic [12:0] got, e;
    mon_cycle++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {playEn, roundReset, p1Score, p2Score, countdown, matchOver, winner};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL outputs cycle %0d: got pe=%b rr=%b s1=%0d s2=%0d cd=%0d mo=%b w=%b, expected pe=%b rr=%b s1=%0d s2=%0d cd=%0d mo=%b w=%b",
                 mon_cycle, got[12], got[11], got[10:8], got[7:5], got[4:3], got[2], got[1:0],
                 e[12], e[11], e[10:8], e[7:5], e[4:3], e[2], e[1:0]);
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    // first round start, countdown to play
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    ticks(3);
    // player 1 takes a round, hold, next countdown
    cyc(0, 0, 0, 1, 0);
    ticks(2);
    ticks(3);
    // draw
    cyc(0, 0, 0, 1, 1);
    ticks(2);
    ticks(3);
    // player 2 runs out the match
    for (int r = 0; r < 4; r++) begin
      cyc(0, 0, 0, 0, 1);
      if (r < 3) begin
        ticks(2);
        ticks(3);
      end
    end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // wins outside play, then reset in the middle of play at 2-0
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 1);
    ticks(3);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    ticks(3);
    cyc(0, 0, 0, 1, 0);
    ticks(2);
    ticks(3);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // random play
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 999) < 3,
          $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 15,
          $urandom_range(0, 99) < 15);
    end
    Reset = 1'b0; Start = 1'b0; TickEn = 1'b0; P1RoundWin = 1'b0; P2RoundWin = 1'b0;
    @(negedge Clock);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter WINS_TO_MATCH, default 4, round wins needed to take the match; legal range 1..7.
REQ-002 Parameter COUNT_TICKS, default 3, TickEn pulses in the pre-round countdown; legal range 1..3.
REQ-003 Parameter HOLD_TICKS, default 2, TickEn pulses held after a round ends; legal range 1..7.
REQ-004 Clock  input  1  system clock; all state changes on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  level request to begin a match, or to clear a finished match.
REQ-007 TickEn  input  1  single-cycle timebase strobe.
REQ-008 P1RoundWin  input  1  single-cycle pulse: player 1 won the current round.
REQ-009 P2RoundWin  input  1  single-cycle pulse: player 2 won the current round.
REQ-010 playEn  output  1  high only in PLAY; enables the playfield and button logic.
REQ-011 roundReset  output  1  single-cycle pulse that re-centres the playfield.
REQ-012 p1Score  output  3  player 1 round wins, unsigned.
REQ-013 p2Score  output  3  player 2 round wins, unsigned.
REQ-014 countdown  output  2  remaining countdown ticks; 0 outside COUNTDOWN.
REQ-015 matchOver  output  1  high only in MATCH_END.
REQ-016 winner  output  2  00 none, 01 player 1, 10 player 2; valid while matchOver.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, COUNTDOWN, PLAY, ROUND_END and MATCH_END.
REQ-018 IDLE with Start=1 SHALL go to COUNTDOWN on the next edge, load countdown=COUNT_TICKS and assert roundReset for that one following cycle.
REQ-019 In COUNTDOWN, each TickEn SHALL decrement countdown.
REQ-020 In COUNTDOWN, TickEn with countdown==1 SHALL go to PLAY with countdown=0.
REQ-021 playEn SHALL be a registered output, high exactly during the cycles ps==PLAY.
REQ-022 In PLAY, P1RoundWin&~P2RoundWin SHALL increment p1Score; the mirror case SHALL increment p2Score.
REQ-023 After a single-player win, the FSM SHALL go to MATCH_END if the new score equals WINS_TO_MATCH, otherwise to ROUND_END.
REQ-024 Both win pulses in the same PLAY cycle SHALL count as a draw: no score change, go to ROUND_END.
REQ-025 Win pulses outside PLAY SHALL be ignored.
REQ-026 ROUND_END SHALL count HOLD_TICKS TickEn pulses, then go to COUNTDOWN, reloading countdown and pulsing roundReset once.
REQ-027 In MATCH_END, winner SHALL hold the player who reached WINS_TO_MATCH, and the scores SHALL freeze.
REQ-028 Start in MATCH_END SHALL go to IDLE and clear both scores and winner.
REQ-029 Start in COUNTDOWN, PLAY or ROUND_END SHALL be ignored.
REQ-030 Scores SHALL never exceed WINS_TO_MATCH; no wrap-around is possible.
REQ-031 roundReset SHALL never be high for two consecutive cycles.

Reset
REQ-032 Reset=1 at any edge, including mid-round, SHALL force IDLE, scores 0, countdown 0, winner 00, and playEn, roundReset and matchOver 0.
REQ-033 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-034 Package match_pkg SHALL hold the state enum, the winner encoding constants (NONE, P1, P2) and the default parameter values.
REQ-035 Tick counting for COUNTDOWN and ROUND_END SHALL be a single sub-module, tick_timer (load value, TickEn decrement, done flag), shared by both states.

Verification
REQ-036 Reset, then Start=1 for 1 cycle, then 3 TickEn -> roundReset pulses once, countdown 3,2,1,0, and playEn rises on the cycle after the 3rd tick.
REQ-037 In PLAY, P1RoundWin pulse -> p1Score=1, ROUND_END, and after 2 TickEn a new countdown with one roundReset pulse.
REQ-038 In PLAY, P1RoundWin and P2RoundWin pulsed together -> both scores unchanged, ROUND_END entered.
REQ-039 Player 2 wins 4 rounds -> p2Score=4, matchOver=1, winner=10; later win pulses leave the scores unchanged; Start -> IDLE with scores 0.
REQ-040 Reset asserted mid-PLAY with p1Score=2 -> next cycle IDLE, all outputs at reset values.
REQ-041 Win pulses during COUNTDOWN and ROUND_END -> no score change.
